// File: rtl/regfile_loader.sv
// regfile_loader: debug preload engine for the CPU register file.
// Holds the processor in reset, streams (reg, value) words from a host
// through a small FIFO into the register file write port, then releases
// the processor after a programmable number of cycles.
module regfile_loader #(
  parameter int DEPTH          = 4,
  parameter int RELEASE_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [5:0]  load_count,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_reg,
  input  logic [31:0] in_data,
  input  logic        in_last,
  input  logic        proc_we,
  input  logic [4:0]  proc_rd,
  input  logic [31:0] proc_data,
  output logic        ctrl_writeEnable,
  output logic [4:0]  ctrl_writeReg,
  output logic [31:0] data_writeReg,
  output logic        cpu_reset
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(RELEASE_CYCLES + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HALT  = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_REL   = 3'd4;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } entry_t;

  logic [2:0]    state, state_nxt;
  entry_t        mem [DEPTH];
  logic [AW:0]   wptr, rptr, occ;
  logic [CW-1:0] rel_cnt;
  logic          full, empty, push, pop, head_wr;
  entry_t        head;

  // Pointers carry one extra wrap bit; occupancy MSB set means exactly DEPTH.
  assign occ      = wptr - rptr;
  assign full     = occ[AW];
  assign empty    = (wptr == rptr);
  assign head     = mem[rptr[AW-1:0]];
  // Registered-state only: a pop in the same cycle never reopens a full FIFO.
  assign in_ready = (state == S_LOAD) && !full;
  assign push     = in_valid && in_ready;
  // Pops use registered occupancy, so a word pushed this cycle waits one edge.
  assign pop      = ((state == S_LOAD) || (state == S_DRAIN)) && !empty;
  assign head_wr  = pop && (head.rd != 5'd0);

  assign busy      = (state != S_IDLE);
  assign done      = (state == S_REL) && (rel_cnt == '0);
  assign cpu_reset = (state == S_HALT) || (state == S_LOAD) || (state == S_DRAIN) ||
                     ((state == S_REL) && (rel_cnt != '0));

  // Next-state selection for the load sequence.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_HALT;
      S_HALT:  state_nxt = S_LOAD;
      S_LOAD:  if (push && in_last) state_nxt = S_DRAIN;
      S_DRAIN: if (empty) state_nxt = S_REL;
      S_REL:   if (rel_cnt == '0) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, FIFO pointers, status flags and release down-counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      wptr       <= '0;
      rptr       <= '0;
      rel_cnt    <= '0;
      error      <= 1'b0;
      load_count <= '0;
    end else begin
      state <= state_nxt;
      if ((state == S_IDLE) && start) begin
        wptr       <= '0;
        rptr       <= '0;
        error      <= 1'b0;
        load_count <= '0;
      end else begin
        if (push) wptr <= wptr + 1'b1;
        if (pop) rptr <= rptr + 1'b1;
        if (pop && (head.rd == 5'd0)) error <= 1'b1;
        if (head_wr && (load_count != 6'd63)) load_count <= load_count + 6'd1;
      end
      if ((state == S_DRAIN) && empty) rel_cnt <= CW'(RELEASE_CYCLES);
      else if ((state == S_REL) && (rel_cnt != '0)) rel_cnt <= rel_cnt - 1'b1;
    end
  end

  // FIFO storage; contents need no reset since pointers define validity.
  always_ff @(posedge clock) begin
    if (push) mem[wptr[AW-1:0]] <= entry_t'{rd: in_reg, data: in_data};
  end

  // Write-port mux: processor passthrough in IDLE, FIFO head otherwise.
  always_comb begin
    ctrl_writeEnable = proc_we;
    ctrl_writeReg    = proc_rd;
    data_writeReg    = proc_data;
    if (state != S_IDLE) begin
      ctrl_writeEnable = head_wr;
      ctrl_writeReg    = pop ? head.rd   : 5'd0;
      data_writeReg    = pop ? head.data : 32'd0;
    end
  end
endmodule

// File: tb/tb_regfile_loader.sv
// tb_regfile_loader: directed + randomized checks of the preload engine
// against a register-file image computed from the host word list.
module tb_regfile_loader;
  localparam int DEPTH = 4;
  localparam int RC    = 2;

  logic        clock = 1'b0;
  logic        reset, start, in_valid, in_last, proc_we;
  logic [4:0]  in_reg, proc_rd;
  logic [31:0] in_data, proc_data;
  logic        busy, done, error, in_ready, ctrl_writeEnable, cpu_reset;
  logic [5:0]  load_count;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;

  regfile_loader #(.DEPTH(DEPTH), .RELEASE_CYCLES(RC)) dut (
    .clock(clock), .reset(reset), .start(start), .busy(busy), .done(done),
    .error(error), .load_count(load_count), .in_valid(in_valid),
    .in_ready(in_ready), .in_reg(in_reg), .in_data(in_data), .in_last(in_last),
    .proc_we(proc_we), .proc_rd(proc_rd), .proc_data(proc_data),
    .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
    .data_writeReg(data_writeReg), .cpu_reset(cpu_reset)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
    int          c;
  } wr_t;

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  logic [31:0] rf     [32];
  logic [31:0] exp_rf [32];
  wr_t         wlog [$];

  // Register file stand-in: r0 hardwired, cleared by reset; logs every write strobe.
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (reset) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (ctrl_writeEnable) begin
      if (ctrl_writeReg != 5'd0) rf[ctrl_writeReg] <= data_writeReg;
      wlog.push_back('{ctrl_writeReg, data_writeReg, cyc + 1});
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_start();
    wlog.delete();
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0; proc_we = 1'b1; proc_rd = 5'd6; proc_data = 32'h55;
    #1;
    chk("halt_busy", busy, 1);
    chk("halt_cpu_reset", cpu_reset, 1);
    chk("halt_in_ready", in_ready, 0);
    chk("halt_we_forced", ctrl_writeEnable, 0);
    @(negedge clock); proc_we = 1'b0;
    #1;
    chk("load_in_ready", in_ready, 1);
  endtask

  task automatic send(input wr_t w[$], input int gap_pct, input bit mark_last, output int acc);
    int i = 0;
    int guard = 0;
    acc = 0;
    while (i < w.size() && guard < 2000) begin
      @(negedge clock);
      guard++;
      in_valid = ($urandom_range(99) >= gap_pct);
      in_reg   = w[i].r;
      in_data  = w[i].d;
      in_last  = mark_last && (i == w.size() - 1);
      #1;
      if (in_valid && in_ready) begin
        i++;
        acc = cyc + 1;
      end
    end
    chk("send_complete", i, w.size());
    @(negedge clock); in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_done(output int dc);
    bit found = 0;
    dc = 0;
    for (int k = 0; k < 300 && !found; k++) begin
      @(negedge clock);
      if (done) begin
        found = 1;
        dc = cyc;
        chk("done_cpu_reset_low", cpu_reset, 0);
      end
    end
    chk("done_seen", found, 1);
    @(negedge clock);
    chk("idle_after_done", busy, 0);
  endtask

  // Reference: apply words in arrival order, skip r0, count real writes.
  task automatic check_load(input string tag, input wr_t w[$]);
    int   cnt = 0;
    int   nb = 0;
    bit   ok = 1;
    logic err = 0;
    wr_t  ew [$];
    foreach (w[i]) begin
      if (w[i].r == 5'd0) err = 1;
      else begin
        cnt++;
        exp_rf[w[i].r] = w[i].d;
        ew.push_back(w[i]);
      end
    end
    if (cnt > 63) cnt = 63;
    chk({tag, "_count"}, load_count, cnt);
    chk({tag, "_error"}, error, err);
    chk({tag, "_nwrites"}, wlog.size(), ew.size());
    for (int i = 0; i < ew.size() && i < wlog.size(); i++)
      if (wlog[i].r !== ew[i].r || wlog[i].d !== ew[i].d) ok = 0;
    chk({tag, "_order"}, ok, 1);
    for (int i = 0; i < 32; i++) if (rf[i] !== exp_rf[i]) nb++;
    chk({tag, "_regs"}, nb, 0);
  endtask

  initial begin
    wr_t w [$];
    int  acc, dc, n;
    bit  nobub;
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_reg = '0; in_data = '0; proc_we = 1'b0; proc_rd = 5'd17; proc_data = 32'h1234_5678;
    for (int i = 0; i < 32; i++) exp_rf[i] = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_count", load_count, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_cpu_reset", cpu_reset, 0);
    chk("rst_pass_rd", ctrl_writeReg, 17);
    chk("rst_pass_data", data_writeReg, 32'h1234_5678);

    // IDLE passthrough write r3=42
    @(negedge clock); proc_we = 1'b1; proc_rd = 5'd3; proc_data = 32'd42;
    #1;
    chk("pass_we", ctrl_writeEnable, 1);
    @(negedge clock); proc_we = 1'b0;
    exp_rf[3] = 32'd42;
    chk("pass_r3", rf[3], 42);

    // single word
    do_start();
    w = '{'{5'd5, 32'hDEADBEEF, 0}};
    send(w, 0, 1, acc);
    wait_done(dc);
    if (wlog.size() > 0) begin
      chk("single_latency", wlog[0].c, acc + 1);
      chk("single_done_delay", dc - wlog[0].c, RC + 1);
    end
    check_load("single", w);

    // full burst r1..r31 = i*3, no bubbles
    do_start();
    w.delete();
    for (int i = 1; i < 32; i++) w.push_back('{5'(i), 32'(i * 3), 0});
    send(w, 0, 1, acc);
    wait_done(dc);
    nobub = 1;
    for (int i = 1; i < wlog.size(); i++) if (wlog[i].c != wlog[0].c + i) nobub = 0;
    chk("burst_no_bubble", nobub, 1);
    check_load("burst", w);

    // intermittent valid, 6 random words
    do_start();
    w.delete();
    for (int i = 0; i < 6; i++) w.push_back('{5'($urandom_range(31, 1)), $urandom, 0});
    send(w, 45, 1, acc);
    wait_done(dc);
    check_load("gappy", w);

    // r0 + duplicate, with start and proc_we during LOAD ignored
    do_start();
    w = '{'{5'd0, 32'd7, 0}};
    send(w, 0, 0, acc);
    start = 1'b1; proc_we = 1'b1; proc_rd = 5'd4; proc_data = 32'd99;
    #1;
    chk("load_proc_we_blocked", ctrl_writeEnable, 0);
    @(negedge clock); start = 1'b0;
    #1;
    chk("load_start_ignored_err", error, 1);
    @(negedge clock); proc_we = 1'b0;
    w = '{'{5'd9, 32'd1, 0}, '{5'd9, 32'd2, 0}};
    send(w, 0, 1, acc);
    wait_done(dc);
    w = '{'{5'd0, 32'd7, 0}, '{5'd9, 32'd1, 0}, '{5'd9, 32'd2, 0}};
    check_load("r0dup", w);
    chk("r0_reads_zero", rf[0], 0);

    // random loads including r0 targets
    for (int t = 0; t < 3; t++) begin
      do_start();
      w.delete();
      n = $urandom_range(12, 1);
      for (int i = 0; i < n; i++) w.push_back('{5'($urandom_range(31)), $urandom, 0});
      send(w, $urandom_range(60), 1, acc);
      wait_done(dc);
      check_load($sformatf("rand%0d", t), w);
    end

    // saturation of load_count
    do_start();
    w.delete();
    for (int i = 0; i < 70; i++) w.push_back('{5'($urandom_range(31, 1)), $urandom, 0});
    send(w, 0, 1, acc);
    wait_done(dc);
    check_load("sat", w);

    // reset after 2 of 5 words
    do_start();
    w.delete();
    for (int i = 0; i < 2; i++) w.push_back('{5'($urandom_range(31, 1)), $urandom, 0});
    send(w, 0, 0, acc);
    reset = 1'b1;
    @(negedge clock); reset = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_cpu_reset", cpu_reset, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_count", load_count, 0);
    for (int i = 0; i < 32; i++) exp_rf[i] = '0;
    do_start();
    w.delete();
    for (int i = 0; i < 3; i++) w.push_back('{5'($urandom_range(31, 1)), $urandom, 0});
    send(w, 20, 1, acc);
    wait_done(dc);
    check_load("after_rst", w);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/regfile_loader.md
# regfile_loader

Debug preload engine for the register file of the pipelined CPU. On request it holds the processor in reset, accepts (register, value) words from a host over a valid/ready stream, and writes them through the register file's single write port. It then releases the processor so a test starts from a known register state. It is the writer that pairs with the register-dump path, which reads registers back through hijacked read port A. It sits between the processor's writeback outputs and the register file's write inputs.

## Interface
- DEPTH, 4, entries in the input FIFO; must be a power of 2 and at least 2.
- RELEASE_CYCLES, 2, cycles `cpu_reset` stays high after the last write; must be at least 1.

- clock  in  1  single system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; clears all block state.
- start  in  1  one-cycle request to begin a load; ignored unless in IDLE.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when RELEASE completes.
- error  out  1  sticky; set when a word targets r0; cleared by `start` or `reset`.
- load_count  out  6  number of register writes performed in the current load; saturates at 63.
- in_valid  in  1  host word valid.
- in_ready  out  1  loader can accept a word this cycle.
- in_reg  in  5  target register.
- in_data  in  32  value to write.
- in_last  in  1  marks the final word of the load.
- proc_we, proc_rd, proc_data  in  1/5/32  processor writeback: `ctrl_writeEnable`, `ctrl_writeReg`, `data_writeReg`.
- ctrl_writeEnable, ctrl_writeReg, data_writeReg  out  1/5/32  register file write port.
- cpu_reset  out  1  OR-ed with `reset` into the processor only; the register file's reset stays tied to `reset`.

## Operation
- States: IDLE, HALT, LOAD, DRAIN, RELEASE.
- IDLE:
  - Write port passes the `proc_*` inputs through combinationally.
  - `in_ready`=0, `cpu_reset`=0.
  - `start` moves to HALT, clears `load_count` and `error`, and empties the FIFO.
- HALT:
  - `cpu_reset`=1 for exactly one cycle, flushing in-flight writebacks.
  - The write port is forced idle (`ctrl_writeEnable`=0).
  - Next state is LOAD.
- LOAD:
  - `cpu_reset`=1.
  - `in_ready` = FIFO not full.
  - A word is accepted when `in_valid && in_ready`.
  - Accepting a word with `in_last`=1 moves to DRAIN. No further words are accepted until the next `start`.
- Write port in LOAD and DRAIN:
  - When the FIFO is non-empty, the head entry drives the port: `ctrl_writeEnable`=1 if `in_reg`≠0, `ctrl_writeReg`=`in_reg`, `data_writeReg`=`in_data`.
  - The head is popped at that edge.
  - A head with register 0 is popped without a write (`ctrl_writeEnable`=0) and sets `error`.
  - `load_count` increments on every write performed, i.e. on each pop with `in_reg`≠0.
  - When the FIFO is empty, `ctrl_writeEnable`=0 and the `proc_*` inputs are ignored.
- DRAIN:
  - `in_ready`=0.
  - Pops continue until the FIFO is empty, then the block moves to RELEASE.
- RELEASE:
  - `cpu_reset`=1 for RELEASE_CYCLES cycles, counted by a down-counter.
  - Then `done`=1 for one cycle as the block returns to IDLE.
  - `cpu_reset` drops in that same cycle.
- Duplicate targets are written in arrival order, so the last word wins.

## Timing
- Values after `reset`: state IDLE, FIFO empty, `busy`=0, `done`=0, `error`=0, `load_count`=0, `in_ready`=0, `cpu_reset`=0. The write port equals the `proc_*` inputs.
- Latency:
  - A word accepted at edge N is at the FIFO head during cycle N→N+1.
  - The register file captures it at edge N+1.
  - A value pushed this cycle is never popped in the same cycle.
- Push and pop in the same cycle are allowed. When full, a simultaneous pop does not raise `in_ready` in that cycle, so `in_ready` depends only on registered state.
- Sustained throughput is 1 word/cycle.
- `start` edge to `cpu_reset`=1: 1 cycle. HALT lasts 1 cycle, so the first possible `in_ready`=1 is 2 cycles after `start`.
- `start` is ignored when `busy`=1.
- `reset` mid-load returns to IDLE immediately and discards FIFO contents. Writes already performed stay in the register file, since the regfile reset is a separate decision made by the top level.
- A single-word load is one word with `in_last`=1: that word passes straight through and the block goes to DRAIN.

## Test plan
- Single word: `start`, send r5=0xDEADBEEF with `in_last` → regfile write at the edge after acceptance; `load_count`=1; `done` pulses exactly RELEASE_CYCLES+1 cycles after the write; r5 reads 0xDEADBEEF.
- Full burst: 31 words r1..r31=i*3, `in_valid` held high, last marked → one write per cycle with no bubbles; `load_count`=31; all registers verified through read port A.
- Backpressure: after LOAD entry, send 6 words back-to-back with DEPTH=4 and the write port held off by no pop stall. Host drops `in_valid` intermittently → `in_ready` never high while full; no word lost or duplicated; arrival order preserved.
- r0 and duplicate: words r0=7, r9=1, r9=2 → `error`=1, `load_count`=2, r0 reads 0, r9 reads 2.
- Passthrough and ignore: in IDLE, `proc_we`=1, rd=3, data=42 → r3=42. `start` pulsed during LOAD → no effect. `proc_we` during LOAD → no write.
- Reset mid-operation: assert `reset` after 2 of 5 words accepted → next cycle `busy`=0, `cpu_reset`=0, `in_ready`=0, FIFO empty; a new `start` loads cleanly.
